// File: rtl/regdst_pkg.sv
// Shared RegDst select codes, fixed register numbers and a saturating adder.
package regdst_pkg;

  typedef enum logic [2:0] {
    SEL_RT = 3'b000,
    SEL_SP = 3'b001,
    SEL_RA = 3'b010,
    SEL_RD = 3'b011,
    SEL_RS = 3'b100
  } sel_e;

  localparam int REG_ZERO = 0;
  localparam int REG_SP   = 29;
  localparam int REG_RA   = 31;

  function automatic logic [31:0] sat_add(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction

endpackage

// File: rtl/regdst_decode.sv
// RegDst select decoder: picks the destination field and flags reserved codes.
module regdst_decode
  import regdst_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [2:0]        issue_sel,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic [ADDR_W-1:0] dest,
  output logic              legal
);

  always_comb begin
    dest  = '0;
    legal = 1'b0;
    unique case (1'b1)
      (issue_sel == SEL_RT): begin
        dest  = rt;
        legal = 1'b1;
      end
      (issue_sel == SEL_SP): begin
        dest  = ADDR_W'(REG_SP);
        legal = 1'b1;
      end
      (issue_sel == SEL_RA): begin
        dest  = ADDR_W'(REG_RA);
        legal = 1'b1;
      end
      (issue_sel == SEL_RD): begin
        dest  = rd;
        legal = 1'b1;
      end
      (issue_sel == SEL_RS): begin
        dest  = rs;
        legal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regdst_pipe.sv
// Tracked destination pipe with RAW hazard detection.
// Optional counters enabled by defining REGDST_STATS_EN.
module regdst_pipe
  import regdst_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [2:0]        issue_sel,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  output logic              hazard_a,
  output logic              hazard_b,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr,
  output logic              err_sel
`ifdef REGDST_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stall,
  output logic [31:0]       stat_killed
`endif
);

  logic [DEPTH-1:0]  vld;
  logic [ADDR_W-1:0] addr [DEPTH];
  logic [ADDR_W-1:0] dest;
  logic              legal;
  logic              accept;
  logic              enter;

  regdst_decode #(.ADDR_W(ADDR_W)) u_dec (
    .issue_sel(issue_sel),
    .rt       (rt),
    .rd       (rd),
    .rs       (rs),
    .dest     (dest),
    .legal    (legal)
  );

  assign accept = issue_valid & ~stall & ~flush;
  assign enter  = accept & reg_write & legal
                & (dest != ADDR_W'(REG_ZERO));

  // Flush overrides the shift for the speculative stages only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld     <= '0;
      err_sel <= 1'b0;
      for (int k = 0; k < DEPTH; k++) addr[k] <= '0;
    end else begin
      err_sel <= accept & ~legal;
      if (!stall) begin
        vld[0]  <= enter;
        addr[0] <= enter ? dest : '0;
        for (int k = 1; k < DEPTH; k++) begin
          vld[k]  <= vld[k-1];
          addr[k] <= addr[k-1];
        end
      end
      if (flush) begin
        for (int k = 0; k < DEPTH - 1; k++) vld[k] <= 1'b0;
      end
    end
  end

  assign wb_valid = vld[DEPTH-1] & ~stall;
  assign wb_addr  = addr[DEPTH-1];

  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && addr[k] == src_a) hazard_a = 1'b1;
      if (vld[k] && addr[k] == src_b) hazard_b = 1'b1;
    end
    if (src_a == '0) hazard_a = 1'b0;
    if (src_b == '0) hazard_b = 1'b0;
  end

`ifdef REGDST_STATS_EN
  logic [31:0] n_kill;

  // Unstalled, the last speculative stage escapes into writeback.
  always_comb begin
    n_kill = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (flush && vld[k] && (stall || k != DEPTH - 2))
        n_kill = n_kill + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_issued <= '0;
      stat_stall  <= '0;
      stat_killed <= '0;
    end else begin
      stat_issued <= sat_add(stat_issued, {31'b0, enter});
      stat_stall  <= sat_add(stat_stall, {31'b0, stall});
      stat_killed <= sat_add(stat_killed, n_kill);
    end
  end
`endif

endmodule
